// File: rtl/aes_inv_main.sv
// aes_inv_main: AES-128 inverse cipher main loop. It processes one state column per clock.
// Optional CBC chaining is compiled in when AES_INV_CBC_EN is defined.

// Inverse S-box leaf: the inverse affine transform, then multiplicative inversion in GF(2^8).
module aes_inv_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse, and it maps 0 to 0 as AES requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] t;
      t = a;
      for (int i = 0; i < 6; i++) t = gf_mul(gf_mul(t, t), a);
      return gf_mul(t, t);
   endfunction

   logic [7:0] aff;
   assign aff = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
   assign y_o = gf_inv(aff);
endmodule

module aes_inv_main (
   input  logic        clk,
   input  logic        rst,
   input  logic        din_valid,
   output logic        din_ready,
   input  logic [31:0] din,
   output logic [3:0]  key_rnd,
   output logic [1:0]  key_col,
   input  logic [31:0] key_word,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic [31:0] dout,
   output logic        busy
`ifdef AES_INV_CBC_EN
   ,
   input  logic        iv_we,
   input  logic [31:0] iv_din
`endif
);
   typedef enum logic [1:0] {S_LOAD = 2'd0, S_RUN = 2'd1, S_OUT = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [1:0]  col_q, col_d;
   logic [3:0]  rnd_q, rnd_d;
   logic [31:0] st_q  [4];
   logic [31:0] st_d  [4];
   logic [31:0] nst_q [4];
   logic [31:0] nst_d [4];
   logic [7:0]  sb_in  [4];
   logic [7:0]  sb_out [4];
   logic [31:0] ark, col_res, out_mask;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [31:0] inv_mix(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   // Row r of the output column comes from column (col - r): this is InvShiftRows
   for (genvar r = 0; r < 4; r++) begin : g_sbox
      logic [1:0] src;
      assign src       = col_q - 2'(r);
      assign sb_in[r]  = st_q[src][31-8*r -: 8];
      aes_inv_sbox u_sbox (.a_i(sb_in[r]), .y_o(sb_out[r]));
   end

   assign ark     = {sb_out[0], sb_out[1], sb_out[2], sb_out[3]} ^ key_word;
   assign col_res = (rnd_q != 4'd0) ? inv_mix(ark) : ark;

`ifdef AES_INV_CBC_EN
   logic [31:0] iv_q [4];
   logic [31:0] iv_d [4];
   logic [31:0] ct_q [4];
   logic [31:0] ct_d [4];
   logic [1:0]  ivcol_q, ivcol_d;
   assign out_mask = iv_q[col_q];
`else
   assign out_mask = 32'h0;
`endif

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      rnd_d      = rnd_q;
      st_d       = st_q;
      nst_d      = nst_q;
`ifdef AES_INV_CBC_EN
      iv_d       = iv_q;
      ct_d       = ct_q;
      ivcol_d    = ivcol_q;
`endif
      din_ready  = 1'b0;
      dout_valid = 1'b0;
      dout       = 32'h0;
      busy       = 1'b1;
      key_rnd    = rnd_q;
      key_col    = col_q;
      case (state_q)
         S_LOAD: begin
            din_ready = 1'b1;
            busy      = 1'b0;
            key_rnd   = 4'd10;
`ifdef AES_INV_CBC_EN
            if (iv_we) begin
               iv_d[ivcol_q] = iv_din;
               ivcol_d       = ivcol_q + 2'd1;
            end
`endif
            if (din_valid) begin
               st_d[col_q] = din ^ key_word;
`ifdef AES_INV_CBC_EN
               ct_d[col_q] = din;
`endif
               col_d = col_q + 2'd1;
               if (col_q == 2'd3) begin
                  state_d = S_RUN;
                  rnd_d   = 4'd9;
               end
            end
         end
         S_RUN: begin
            nst_d[col_q] = col_res;
            col_d        = col_q + 2'd1;
            // The whole state must update together, because every column reads all four old columns
            if (col_q == 2'd3) begin
               for (int i = 0; i < 3; i++) st_d[i] = nst_q[i];
               st_d[3] = col_res;
               if (rnd_q == 4'd0) state_d = S_OUT;
               else               rnd_d   = rnd_q - 4'd1;
            end
         end
         S_OUT: begin
            dout_valid = 1'b1;
            dout       = st_q[col_q] ^ out_mask;
            if (dout_ready) begin
               col_d = col_q + 2'd1;
               if (col_q == 2'd3) begin
                  state_d = S_LOAD;
`ifdef AES_INV_CBC_EN
                  iv_d = ct_q;
`endif
               end
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_LOAD;
         col_q   <= 2'd0;
         rnd_q   <= 4'd0;
         for (int i = 0; i < 4; i++) begin
            st_q[i]  <= 32'h0;
            nst_q[i] <= 32'h0;
`ifdef AES_INV_CBC_EN
            iv_q[i]  <= 32'h0;
            ct_q[i]  <= 32'h0;
`endif
         end
`ifdef AES_INV_CBC_EN
         ivcol_q <= 2'd0;
`endif
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         rnd_q   <= rnd_d;
         st_q    <= st_d;
         nst_q   <= nst_d;
`ifdef AES_INV_CBC_EN
         iv_q    <= iv_d;
         ct_q    <= ct_d;
         ivcol_q <= ivcol_d;
`endif
      end
   end
endmodule

// File: doc/aes_inv_main.md
# aes_inv_main

Inverse-cipher main loop for the AES-128 decrypt path: accepts one 128-bit ciphertext block as four 32-bit column words, runs the initial AddRoundKey plus ten inverse rounds one column per clock, and returns the plaintext as four 32-bit words. It sits between the block input buffer and the output buffer and fetches round-key words from the external precomputed key schedule. Sequencing (load, 40-cycle round loop, drain) is internal.

## Interface
- No parameters; AES-128 only, 10 rounds fixed.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- din_valid  in  1  ciphertext word valid
- din_ready  out  1  block accepts a ciphertext word
- din  in  32  ciphertext column word; [31:24] is row 0
- key_rnd  out  4  round-key index requested (10..0)
- key_col  out  2  round-key column requested
- key_word  in  32  round-key word for (key_rnd, key_col), valid combinationally in the same cycle
- dout_valid  out  1  plaintext word valid
- dout_ready  in  1  downstream accepts plaintext word
- dout  out  32  plaintext column word; 0 when dout_valid=0
- busy  out  1  high in RUN and OUT
- iv_we  in  1  (AES_INV_CBC_EN only) load one IV word
- iv_din  in  32  (AES_INV_CBC_EN only) IV column word; words written in order 0..3

## Operation
- State: st[0..3] (current round state), nst[0..3] (next state), 2-bit col, 4-bit rnd. FSM states LOAD, RUN, OUT; reset enters LOAD.
- LOAD: din_ready=1, key_rnd=10, key_col=col. On din_valid&din_ready: st[col] <= din ^ key_word; col++. Fourth word accepted -> RUN, rnd=9, col=0.
- RUN: per cycle compute column col: byte r = InvSBox(st[(col-r) mod 4] row r) (InvShiftRows+InvSubBytes); XOR key_word (key_rnd=rnd, key_col=col); if rnd!=0 apply InvMixColumns ({0e,0b,0d,09} circulant, GF(2^8) poly 0x11b); write nst[col]. At col=3: st <= nst with column 3 result, col=0; if rnd=0 -> OUT else rnd--.
- InvSBox is a combinational leaf instantiated four times.
- OUT: dout_valid=1, dout=st[col]; on dout_ready col++; fourth word taken -> LOAD, col=0. din_ready=0 throughout RUN/OUT (no overlap of blocks).

## Timing
- Reset values: din_ready=1, dout_valid=0, dout=0, busy=0, key_rnd=10, key_col=0, col=0, rnd=0, st/nst=0.
- Fourth din word accepted at edge T -> RUN cycles T+1..T+40 -> dout_valid high from cycle T+41.
- Minimum block period: 4 load + 40 run + 4 drain = 48 cycles.
- dout_valid stays high and dout stable until dout_ready; back-pressure stalls indefinitely.
- din_valid ignored outside LOAD; dout_ready ignored outside OUT.
- rst mid-block: immediate return to LOAD, partial block discarded, all outputs to reset values.

## Configuration
- AES_INV_CBC_EN defined: CBC chaining. Registers iv[0..3] and ct[0..3]; iv_we writes iv[ivcol], ivcol++ (wraps; ignored while busy). LOAD also captures raw din into ct[col]. In OUT, dout = st[col] ^ iv[col]; on the fourth drained word iv <= ct. iv/ct/ivcol reset to 0.
- Not defined: ECB; iv_we/iv_din ports absent; dout = st[col].

## Test plan
- FIPS-197 C.1: key 000102…0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff; dout_valid exactly 41 cycles after 4th din accept.
- Back-pressure: same vector, dout_ready low 10 cycles then toggling -> dout holds each word stable, order 00112233, 44556677, 8899aabb, ccddeeff; din_ready=0 until last word taken.
- Back-to-back: two blocks, din_valid held high -> second block accepted only after first drained; both correct.
- Reset mid-RUN at round 5 -> outputs at reset values next cycle; fresh block then decrypts correctly.
- AES_INV_CBC_EN, SP800-38A F.2.2: key 2b7e1516…4f3c, IV 000102…0f, ct 7649abac8119b246cee98e9b12e9197d -> pt 6bc1bee22e409f96e93d7e117393172a; next ct 5086cb9b507219ee95db113a917678b2 -> ae2d8a571e03ac9c9eb76fac45af8e51.
- Key-request check: monitor key_rnd/key_col sequence 10/0..3, then 9/0..3 down to 0/0..3, each pair exactly once per block.
